// File: rtl/valid_pipe_credit_fifo.sv
// Credit-managed show-ahead FIFO that absorbs a fixed-latency valid pipeline. A push is visible one cycle later.
// The input side cannot be backpressured. Upstream throttles on can_issue, and out_rdy pops the head.
module valid_pipe_credit_fifo #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    output logic             can_issue,
    input  logic             in_vld,
    input  logic [width-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [width-1:0] out_data,
    output logic             overflow,
    output logic             underflow_credit
);

    localparam int AW      = $clog2(depth);
    localparam int CW      = AW + 1;
    localparam logic [AW:0] DEPTH_C = CW'(depth);

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      r_reserved;
    logic             r_overflow;
    logic             r_underflow_credit;

    logic w_full;
    logic w_pop;
    logic w_push_ok;
    logic w_overflow_evt;
    logic w_issue_ok;
    logic w_credit_pop;
    logic w_credit_err;

    // Outputs are forced to their post-reset values while rst is held.
    assign out_vld   = (r_count != '0) && !rst;
    assign out_data  = r_mem[r_rd_ptr];
    assign can_issue = rst || (r_reserved < DEPTH_C) || ((r_reserved == DEPTH_C) && w_pop);

    assign w_full         = (r_count == DEPTH_C);
    assign w_pop          = out_vld && out_rdy;
    assign w_push_ok      = in_vld && (!w_full || w_pop);
    assign w_overflow_evt = in_vld && w_full && !w_pop;
    assign w_issue_ok     = issue && can_issue;
    assign w_credit_pop   = w_pop && (r_reserved != '0);
    assign w_credit_err   = (issue && !can_issue) || (w_pop && (r_reserved == '0));

    assign overflow         = r_overflow;
    assign underflow_credit = r_underflow_credit;

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr           <= '0;
            r_rd_ptr           <= '0;
            r_count            <= '0;
            r_reserved         <= '0;
            r_overflow         <= 1'b0;
            r_underflow_credit <= 1'b0;
        end else begin
            // Pointers wrap naturally because depth is a power of two.
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_issue_ok, w_credit_pop})
                2'b10:   r_reserved <= r_reserved + 1'b1;
                2'b01:   r_reserved <= r_reserved - 1'b1;
                default: r_reserved <= r_reserved;
            endcase
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_credit_err) begin
                r_underflow_credit <= 1'b1;
            end
        end
    end

endmodule
